// File: rtl/pulse_sched_pkg.sv
// Shared types and defaults for the pulse sync scheduler.
// State encoding plus default spacing and counter width.
package pulse_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam int DEF_GAP   = 4;
  localparam int DEF_CNT_W = 3;

endpackage

// File: rtl/pulse_sched_rr_arb.sv
// Rotating-priority pick of the first set request bit from ptr upward.
// Ports: req/ptr in; idx (chosen requester) and valid out.
module pulse_sched_rr_arb #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  idx,
  output logic             valid
);

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N_REQ]) begin
        idx   = ID_W'((int'(ptr) + k) % N_REQ);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pulse_sync_scheduler.sv
// Queues per-requester event pulses and issues them round-robin, spaced
// GAP+1 cycles apart, into one shared toggle pulse synchronizer.
// Ports: clk, rst_n, en, req_pulse, clr_ovf in;
//        pulse_out, pulse_id, pending, overflow, busy out.
module pulse_sync_scheduler
  import pulse_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = DEF_CNT_W,
  parameter int GAP   = DEF_GAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req_pulse,
  input  logic             clr_ovf,
  output logic             pulse_out,
  output logic [ID_W-1:0]  pulse_id,
  output logic [N_REQ-1:0] pending,
  output logic [N_REQ-1:0] overflow,
  output logic             busy
);

  localparam int GAP_W = (GAP > 2) ? $clog2(GAP) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [N_REQ];
  logic [CNT_W-1:0] cnt_d [N_REQ];
  logic [N_REQ-1:0] ovf_q, ovf_d;
  logic [N_REQ-1:0] dec_v;
  state_e           state_q, state_d;
  logic [ID_W-1:0]  sel_q, sel_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [ID_W-1:0]  arb_idx;
  logic             arb_vld;

  always_comb begin
    pending = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pending[i] = |cnt_q[i];
    end
  end

  pulse_sched_rr_arb #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req   (pending),
    .ptr   (ptr_q),
    .idx   (arb_idx),
    .valid (arb_vld)
  );

  // Event counters: inc and dec in one cycle cancel, so a saturated
  // counter being drained never flags an overflow.
  always_comb begin
    ovf_d = clr_ovf ? '0 : ovf_q;
    dec_v = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      dec_v[i] = (state_q == ISSUE) && (sel_q == ID_W'(i));
      if (req_pulse[i] && !dec_v[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else if (dec_v[i] && !req_pulse[i]) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  // ISSUE is one cycle, WAIT runs GAP-1 cycles, and the IDLE pick
  // cycle completes the GAP+1 spacing.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    gap_d   = gap_q;
    unique case (state_q)
      IDLE: begin
        if (en && arb_vld) begin
          sel_d   = arb_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        ptr_d   = (sel_q == ID_W'(N_REQ - 1)) ? '0 : sel_q + 1'b1;
        gap_d   = GAP_W'(GAP - 2);
        state_d = WAIT;
      end
      WAIT: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      gap_q   <= '0;
      ovf_q   <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      gap_q   <= gap_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign pulse_out = (state_q == ISSUE);
  assign busy      = (state_q != IDLE);
  assign pulse_id  = pulse_out ? sel_q : '0;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pulse_sync_scheduler.sv
// Randomized and directed bench for pulse_sync_scheduler against a
// count-and-timestamp reference model.
module tb_pulse_sync_scheduler;

  localparam int N    = 4;
  localparam int IW   = 2;
  localparam int CW   = 3;
  localparam int GAP  = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          clr_ovf = 1'b0;
  logic [N-1:0]  req_pulse = '0;
  logic          pulse_out;
  logic [IW-1:0] pulse_id;
  logic [N-1:0]  pending;
  logic [N-1:0]  overflow;
  logic          busy;

  always #5 clk = ~clk;

  pulse_sync_scheduler #(
    .N_REQ (N),
    .ID_W  (IW),
    .CNT_W (CW),
    .GAP   (GAP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req_pulse (req_pulse),
    .clr_ovf   (clr_ovf),
    .pulse_out (pulse_out),
    .pulse_id  (pulse_id),
    .pending   (pending),
    .overflow  (overflow),
    .busy      (busy)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Model: queued counts, sticky flags, rr pointer, and the cycle
  // numbers of the next issue and of the next free pick slot.
  int cnt [N];
  bit ovf_m [N];
  int ptr_m, sel_m;
  int c, issue_at, free_at;
  int obs_pulses = 0;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      cnt[i]   = 0;
      ovf_m[i] = 1'b0;
    end
    ptr_m    = 0;
    sel_m    = 0;
    c        = 0;
    issue_at = -1;
    free_at  = 0;
  endfunction

  function automatic bit in_wait();
    return (issue_at >= 0) && (c > issue_at) && (c < free_at);
  endfunction

  task automatic step(input logic [N-1:0] rq,
                      input logic e,
                      input logic cl);
    logic [N-1:0] ep, eo;
    int s;
    bit found;
    for (int i = 0; i < N; i++) begin
      ep[i] = (cnt[i] > 0);
      eo[i] = ovf_m[i];
    end
    chk("pulse_out", pulse_out, (issue_at == c));
    if (issue_at == c) chk("pulse_id", pulse_id, sel_m);
    chk("pending", pending, ep);
    chk("overflow", overflow, eo);
    chk("busy", busy, (c < free_at));
    if (pulse_out) obs_pulses++;
    req_pulse = rq;
    en        = e;
    clr_ovf   = cl;
    s = (issue_at == c) ? sel_m : -1;
    found = 1'b0;
    if (c >= free_at && e) begin
      for (int k = 0; k < N; k++) begin
        if (!found && cnt[(ptr_m + k) % N] > 0) begin
          found    = 1'b1;
          sel_m    = (ptr_m + k) % N;
          issue_at = c + 1;
          free_at  = c + 1 + GAP;
          ptr_m    = (sel_m + 1) % N;
        end
      end
    end
    if (cl) begin
      for (int i = 0; i < N; i++) ovf_m[i] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (rq[i] && s != i) begin
        if (cnt[i] == MAXC) ovf_m[i] = 1'b1;
        else cnt[i]++;
      end else if (!rq[i] && s == i) begin
        cnt[i]--;
      end
    end
    @(posedge clk);
    #1;
    c++;
  endtask

  function automatic logic [N-1:0] rand_req(input int div);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = ($urandom % div) == 0;
    return r;
  endfunction

  int p0;
  bit hit;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    repeat (10) step('0, 1'b1, 1'b0);

    // single event: issue lands two cycles later
    step(4'b0100, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
    chk("single_pulse", pulse_out, 1);
    chk("single_id", pulse_id, 2);
    repeat (3) step('0, 1'b1, 1'b0);
    chk("single_pend", pending, 0);

    // backlog on one requester
    p0 = obs_pulses;
    repeat (3) step(4'b0001, 1'b1, 1'b0);
    repeat (20) step('0, 1'b1, 1'b0);
    chk("backlog_cnt", obs_pulses - p0, 3);

    // round robin then partial burst
    step(4'b1111, 1'b1, 1'b0);
    repeat (25) step('0, 1'b1, 1'b0);
    step(4'b1010, 1'b1, 1'b0);
    repeat (15) step('0, 1'b1, 1'b0);

    // saturation with grants held off
    repeat (8) step(4'b0010, 1'b0, 1'b0);
    chk("sat_ovf", overflow[1], 1);
    chk("sat_pend", pending, 4'b0010);
    p0 = obs_pulses;
    step('0, 1'b1, 1'b1);
    repeat (45) step('0, 1'b1, 1'b0);
    chk("sat_drain", obs_pulses - p0, MAXC);
    chk("sat_clr", overflow, 0);

    // inc during the issue cycle of a full counter
    repeat (MAXC) step(4'b0001, 1'b0, 1'b0);
    p0 = obs_pulses;
    hit = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!hit && issue_at == c && sel_m == 0) begin
        hit = 1'b1;
        step(4'b0001, 1'b1, 1'b0);
      end else begin
        step('0, 1'b1, 1'b0);
      end
    end
    chk("incdec_cnt", obs_pulses - p0, MAXC + 1);
    chk("incdec_ovf", overflow, 0);

    // async reset in the middle of WAIT
    step(4'b0111, 1'b1, 1'b0);
    step(4'b0111, 1'b1, 1'b0);
    for (int i = 0; i < 20 && !in_wait(); i++) step('0, 1'b1, 1'b0);
    chk("rst_pre_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_pulse", pulse_out, 0);
    chk("rst_id", pulse_id, 0);
    chk("rst_pend", pending, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    p0 = obs_pulses;
    repeat (20) step('0, 1'b1, 1'b0);
    chk("rst_quiet", obs_pulses - p0, 0);

    // random traffic: light, then heavy enough to saturate
    for (int i = 0; i < 1500; i++) begin
      step(rand_req(30), ($urandom % 8) != 0, ($urandom % 64) == 0);
    end
    for (int i = 0; i < 500; i++) begin
      step(rand_req(3), ($urandom % 4) != 0, ($urandom % 16) == 0);
    end
    for (int i = 0; i < 300; i++) step('0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
